// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: divider FSM states, step count and
// small two's-complement helpers used by the iterative divider.
package mdu_pkg;

  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned DIV_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Magnitude of a value; only treated as signed when sgn is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract of the divisor
// from the shifted partial remainder, yielding next remainder and quotient bit.
module div_step
  import mdu_pkg::*;
(
  input  logic [32:0] pr_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] diff_s;

  // Partial remainder stays below twice the divisor, so 33 bits hold the signed difference.
  always_comb begin
    diff_s = pr_i - {1'b0, dvs_i};
    q_o    = ~diff_s[32];
    if (q_o) begin
      rem_o = diff_s[31:0];
    end else begin
      rem_o = pr_i[31:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit for the E stage (32 restoring steps).
// Optional macro DIV_EARLY_OUT_EN finishes in one cycle when |a| < |b|.
module div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic        signedE,
  input  logic [31:0] src_aE,
  input  logic [31:0] src_bE,
  input  logic        flushE,
  input  logic        stall_ext,
  output logic        alu_stallE,
  output logic        result_validE,
  output logic [31:0] hiE,
  output logic [31:0] loE
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_CYCLES - 1);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          dvs_q, dvs_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic                 valid_q, valid_d;

  logic [31:0] mag_a_s, mag_b_s;
  logic [31:0] step_rem_s;
  logic        step_q_s;
  logic [31:0] quo_next_s;

  assign mag_a_s    = mag32(src_aE, signedE);
  assign mag_b_s    = mag32(src_bE, signedE);
  assign quo_next_s = {quo_q[30:0], step_q_s};

  // The dividend is shifted out of quo_q MSB-first while quotient bits fill in from the LSB.
  div_step u_step (
    .pr_i  ({rem_q, quo_q[31]}),
    .dvs_i (dvs_q),
    .rem_o (step_rem_s),
    .q_o   (step_q_s)
  );

  assign alu_stallE    = ~flushE & (((state_q == IDLE) & startE) | (state_q == BUSY));
  assign result_validE = valid_q;
  assign hiE           = hi_q;
  assign loE           = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;

    if (flushE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (startE) begin
            rem_d   = 32'd0;
            quo_d   = mag_a_s;
            dvs_d   = mag_b_s;
            negq_d  = signedE & (src_aE[31] ^ src_bE[31]);
            negr_d  = signedE & src_aE[31];
            cnt_d   = {DIV_CNT_W{1'b0}};
            state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
            if ((mag_a_s < mag_b_s) && (mag_b_s != 32'd0)) begin
              state_d = DONE;
              lo_d    = 32'd0;
              hi_d    = src_aE;
              valid_d = 1'b1;
            end else begin
              state_d = BUSY;
            end
`endif
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          rem_d = step_rem_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + DIV_CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Sign fix on the way into DONE: quotient by sign mismatch, remainder follows dividend.
            state_d = DONE;
            lo_d    = neg_if(quo_next_s, negq_q);
            hi_d    = neg_if(step_rem_s, negr_q);
            valid_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
        DONE: begin
          if (stall_ext) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= {DIV_CNT_W{1'b0}};
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: randomized and directed DIV/DIVU against a
// 64-bit arithmetic reference; honours DIV_EARLY_OUT_EN for stall length.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        startE;
  logic        signedE;
  logic [31:0] src_aE;
  logic [31:0] src_bE;
  logic        flushE;
  logic        stall_ext;
  logic        alu_stallE;
  logic        result_validE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int total;
  int bad;
  logic [63:0] exp_q[$];
  logic        prev_valid;

  div_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .startE        (startE),
    .signedE       (signedE),
    .src_aE        (src_aE),
    .src_bE        (src_bE),
    .flushE        (flushE),
    .stall_ext     (stall_ext),
    .alu_stallE    (alu_stallE),
    .result_validE (result_validE),
    .hiE           (hiE),
    .loE           (loE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic; divide-by-zero per architecture rule.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    logic [31:0] hi, lo;
    if (b == 32'd0) begin
      hi = a;
      lo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
    return {hi, lo};
  endfunction

  function automatic int exp_stall(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint ma, mb;
    ma = sgn ? ((longint'($signed(a)) < 0) ? -longint'($signed(a)) : longint'($signed(a))) : longint'(a);
    mb = sgn ? ((longint'($signed(b)) < 0) ? -longint'($signed(b)) : longint'($signed(b))) : longint'(b);
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb && mb != 0) return 1;
`endif
    return 33;
  endfunction

  // Monitor: each rising result_validE consumes one scoreboard entry.
  initial begin
    logic [63:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (result_validE && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("hi", hiE, e[63:32]);
          chk("lo", loE, e[31:0]);
        end
      end
      prev_valid = result_validE;
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int hold);
    int n;
    logic [31:0] hs, ls;
    exp_q.push_back(ref_div(a, b, sgn));
    @(posedge clk); #1;
    startE    = 1'b1;
    signedE   = sgn;
    src_aE    = a;
    src_bE    = b;
    stall_ext = (hold > 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!alu_stallE) break;
      n++;
      @(posedge clk); #1;
      startE = 1'b0;
    end
    startE = 1'b0;
    chk("stall_cycles", 32'(n), 32'(exp_stall(a, b, sgn)));
    chk("valid_at_end", {31'd0, result_validE}, 32'd1);
    if (hold > 0) begin
      hs = hiE;
      ls = loE;
      for (int k = 1; k < hold; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_valid", {31'd0, result_validE}, 32'd1);
        chk("hold_hi", hiE, hs);
        chk("hold_lo", loE, ls);
      end
      @(posedge clk); #1;
      stall_ext = 1'b0;
      @(negedge clk);
      chk("release_valid", {31'd0, result_validE}, 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_valid", {31'd0, result_validE}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    total     = 0;
    bad       = 0;
    resetn    = 1'b0;
    startE    = 1'b0;
    signedE   = 1'b0;
    src_aE    = 32'd0;
    src_bE    = 32'd0;
    flushE    = 1'b0;
    stall_ext = 1'b0;
    #12;
    chk("rst_valid", {31'd0, result_validE}, 32'd0);
    chk("rst_hi", hiE, 32'd0);
    chk("rst_lo", loE, 32'd0);
    chk("rst_stall", {31'd0, alu_stallE}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_div(32'd7, 32'd0, 1'b0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'd3, 32'd10, 1'b0, 0);
    run_div(32'hFFFF_FFFD, 32'd10, 1'b1, 0);
    run_div(32'd1000, 32'd9, 1'b0, 5);

    // Flush at counter 10 (cycle T+11), then a fresh divide.
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b0; src_aE = 32'd12345; src_bE = 32'd7;
    @(posedge clk); #1;
    startE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flushE = 1'b1;
    @(negedge clk);
    chk("flush_stall_mask", {31'd0, alu_stallE}, 32'd0);
    @(posedge clk); #1;
    flushE = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, alu_stallE}, 32'd0);
    chk("flush_no_valid", {31'd0, result_validE}, 32'd0);
    run_div(32'd9, 32'd3, 1'b0, 0);

    // Flush beats a simultaneous start.
    @(posedge clk); #1;
    startE = 1'b1; flushE = 1'b1; src_aE = 32'd50; src_bE = 32'd5;
    @(negedge clk);
    chk("flush_start_stall", {31'd0, alu_stallE}, 32'd0);
    @(posedge clk); #1;
    startE = 1'b0; flushE = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", {31'd0, alu_stallE}, 32'd0);

    // Reset mid-divide abandons it.
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b0; src_aE = 32'd999; src_bE = 32'd4;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, alu_stallE}, 32'd0);
    chk("midrst_hi", hiE, 32'd0);
    chk("midrst_lo", loE, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_div(32'd100, 32'd7, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      ra = $urandom;
      rb = (t % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (t % 4 == 1) rb = rb >> $urandom_range(0, 31);
      if (t == 7) rb = 32'd0;
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, (t % 5 == 4) ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; the cycle count is fixed by the shared package constant DIV_CYCLES = 32.
REQ-002 SHALL have port `clk`, input, width 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port `resetn`, input, width 1: asynchronous, active-low reset.
REQ-004 SHALL have port `startE`, input, width 1: a DIV or DIVU instruction is in the E stage.
REQ-005 SHALL have port `signedE`, input, width 1: 1 = DIV, 0 = DIVU.
REQ-006 SHALL have port `src_aE`, input, width 32: dividend.
REQ-007 SHALL have port `src_bE`, input, width 32: divisor.
REQ-008 SHALL have port `flushE`, input, width 1: abort request, driven by the exception flush.
REQ-009 SHALL have port `stall_ext`, input, width 1: cache stall; while high, E cannot advance.
REQ-010 SHALL have port `alu_stallE`, output, width 1: holds F through W while a divide is running.
REQ-011 SHALL have port `result_validE`, output, width 1: `hiE`/`loE` are final.
REQ-012 SHALL have port `hiE`, output, width 32: remainder.
REQ-013 SHALL have port `loE`, output, width 32: quotient.

Function
REQ-014 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-015 IDLE with startE=1 and flushE=0 SHALL latch |a|, |b| (or the raw values if unsigned) and both operand signs, clear counter, and go to BUSY.
REQ-016 alu_stallE SHALL be a combinational output equal to ~flushE & ((IDLE & startE) | BUSY), so it is high in the start cycle itself.
REQ-017 BUSY SHALL perform one restoring-division step per cycle, counter 0..31, using a 33-bit partial-remainder subtract; the state SHALL move to DONE after the step with counter=31.
REQ-018 Latency (DIVU, or DIV with no early-out): start at cycle T; alu_stallE high for T..T+32 (33 cycles); result_validE=1 and alu_stallE=0 at T+33.
REQ-019 Sign fix SHALL be applied when entering DONE:
  - quotient negated when signedE and the operand signs differ;
  - remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL return the raw algorithm result: unsigned quotient 0xFFFFFFFF and remainder = dividend magnitude, then the normal sign fix.
REQ-021 DONE SHALL hold hiE/loE/result_validE while stall_ext=1, then return to IDLE in the first cycle with stall_ext=0; startE seen in DONE SHALL NOT restart.
REQ-022 flushE=1 in any state SHALL force IDLE on the next edge, mask alu_stallE the same cycle, and discard the partial result; flush has priority over a simultaneous start.
REQ-023 The 0x80000000 / 0xFFFFFFFF signed case SHALL produce LO=0x80000000, HI=0 (wrap-around, no trap).
REQ-024 Outputs SHALL be registered except alu_stallE.

Reset
REQ-025 resetn=0 SHALL asynchronously force: state IDLE, counter 0, hiE=0, loE=0, result_validE=0; alu_stallE therefore =0 unless startE.
REQ-026 Reset mid-BUSY SHALL abandon the operation; the first startE after release begins a fresh divide.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN SHALL control early-out:
  - Defined: in IDLE with start, if magnitude(a) < magnitude(b) and b≠0, go directly to DONE with Q=0, R=a (signed a kept as-is); alu_stallE high only for cycle T; result valid at T+1.
  - Undefined: every divide takes the full 33-cycle stall.

Structure
REQ-028 Package `mdu_pkg` SHALL hold the state enum typedef div_state_t and the constant DIV_CYCLES.
REQ-029 One sub-module `div_step` SHALL implement a single combinational restoring step: partial remainder and divisor in; next remainder and quotient bit out.

Verification
REQ-030 DIVU 100/7, stall_ext=0 -> alu_stallE high exactly 33 cycles; LO=14, HI=2.
REQ-031 DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 7/-2 -> LO=-3, HI=1.
REQ-032 DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 flushE pulse at BUSY counter=10 -> IDLE next cycle; alu_stallE low that cycle; next DIVU 9/3 -> LO=3, HI=0.
REQ-034 stall_ext held high 5 cycles after DONE -> result_validE and HI/LO stable for all 5 cycles; IDLE on the first cycle with stall_ext low.
REQ-035 With DIV_EARLY_OUT_EN, DIVU 3/10 -> alu_stallE high 1 cycle, LO=0, HI=3; without the macro -> 33 cycles, same result.
